// File: rtl/gpx2_cfg_ctrl.sv
// GPX2 TDC configuration sequencer: drives the byte SPI master and owns SSN.
// Optional readback verify frame is compiled in with `define GPX2_CFG_VERIFY_EN.
//
// state      | meaning
// -----------+--------------------------------------------------------
// S_IDLE     | waiting for start, SSN high
// S_CS_SETUP | SSN low, setup delay before the first byte of a frame
// S_SEND     | waiting for SPI master ready, then issue one byte req
// S_WAIT     | byte in flight, timeout running
// S_CS_HOLD  | SSN still low, hold delay after the last byte
// S_CS_GAP   | SSN high, minimum inter-frame gap
// S_FINISH   | done pulse after a completed sequence
// S_ABORT    | done pulse after a byte timeout, err set
module gpx2_cfg_ctrl #(
  parameter int CFG_REG_NUM         = 17,
  parameter int CS_GAP_CLKCNT       = 8,
  parameter int BYTE_TIMEOUT_CLKCNT = 1023
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_cfg_start,
  input  logic [CFG_REG_NUM*8-1:0] i_cfg_data,
  output logic                     o_cfg_busy,
  output logic                     o_cfg_done,
  output logic                     o_cfg_err,
  output logic                     o_spi_ssn,
  output logic                     o_spicom_req,
  output logic [7:0]               o_spi_wdata,
  input  logic                     i_spicom_ready,
  input  logic                     i_spi_rdvalid,
  input  logic [7:0]               i_spi_rdbyte
);

  localparam int TMAX = (CS_GAP_CLKCNT > BYTE_TIMEOUT_CLKCNT) ? CS_GAP_CLKCNT : BYTE_TIMEOUT_CLKCNT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int BW   = $clog2(CFG_REG_NUM + 2);
  localparam logic [TW-1:0] GAP_LOAD = TW'(CS_GAP_CLKCNT - 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(BYTE_TIMEOUT_CLKCNT - 1);

`ifdef GPX2_CFG_VERIFY_EN
  localparam logic [1:0] FRAME_AFTER_F1 = 2'd2;
`else
  localparam logic [1:0] FRAME_AFTER_F1 = 2'd3;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_CS_SETUP, S_SEND, S_WAIT, S_CS_HOLD, S_CS_GAP, S_FINISH, S_ABORT
  } state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   tmr, tmr_nxt;
  logic [BW-1:0]   byte_idx, byte_nxt, reg_sel;
  logic [1:0]      frame, frame_nxt;
  logic            err, err_nxt;
  logic            ssn, ssn_nxt;
  logic            req, req_nxt;
  logic [7:0]      wdata, wdata_nxt;
  logic            latch;
  logic [7:0]      img_q [CFG_REG_NUM];
  logic [7:0]      opcode, tx_byte;
  logic            last_byte, mismatch;

  assign reg_sel = byte_idx - 1'b1;

  always_comb begin
    case (frame)
      2'd0:    opcode = 8'h30;
      2'd1:    opcode = 8'h80;
      2'd2:    opcode = 8'h40;
      default: opcode = 8'h18;
    endcase
  end

  assign tx_byte   = (byte_idx == '0) ? opcode : ((frame == 2'd1) ? img_q[reg_sel] : 8'h00);
  assign last_byte = (frame == 2'd1 || frame == 2'd2) ? (byte_idx == BW'(CFG_REG_NUM)) : (byte_idx == '0);
  // Frame 2 is unreachable unless the verify frame is enabled, so this stays inert otherwise.
  assign mismatch  = (frame == 2'd2) && (byte_idx != '0) && (i_spi_rdbyte != img_q[reg_sel]);

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    byte_nxt  = byte_idx;
    frame_nxt = frame;
    err_nxt   = err;
    req_nxt   = 1'b0;
    wdata_nxt = wdata;
    latch     = 1'b0;
    case (state)
      S_IDLE: if (i_cfg_start) begin
        latch     = 1'b1;
        err_nxt   = 1'b0;
        frame_nxt = 2'd0;
        byte_nxt  = '0;
        tmr_nxt   = GAP_LOAD;
        state_nxt = S_CS_SETUP;
      end
      S_CS_SETUP: if (tmr == '0) state_nxt = S_SEND; else tmr_nxt = tmr - 1'b1;
      S_SEND: if (i_spicom_ready) begin
        req_nxt   = 1'b1;
        wdata_nxt = tx_byte;
        tmr_nxt   = TMO_LOAD;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (i_spi_rdvalid) begin
          if (mismatch) err_nxt = 1'b1;
          if (last_byte) begin
            byte_nxt  = '0;
            tmr_nxt   = GAP_LOAD;
            state_nxt = S_CS_HOLD;
          end else begin
            byte_nxt  = byte_idx + 1'b1;
            state_nxt = S_SEND;
          end
        end else if (tmr == '0) begin
          err_nxt   = 1'b1;
          state_nxt = S_ABORT;
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      S_CS_HOLD: begin
        if (tmr == '0) begin
          tmr_nxt   = GAP_LOAD;
          state_nxt = S_CS_GAP;
        end else tmr_nxt = tmr - 1'b1;
      end
      S_CS_GAP: begin
        if (tmr != '0) tmr_nxt = tmr - 1'b1;
        else if (frame == 2'd3) state_nxt = S_FINISH;
        else begin
          frame_nxt = (frame == 2'd1) ? FRAME_AFTER_F1 : frame + 2'd1;
          tmr_nxt   = GAP_LOAD;
          state_nxt = S_CS_SETUP;
        end
      end
      S_FINISH, S_ABORT: begin
        tmr_nxt   = '0;
        byte_nxt  = '0;
        frame_nxt = 2'd0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    ssn_nxt = !(state_nxt == S_CS_SETUP || state_nxt == S_SEND ||
                state_nxt == S_WAIT || state_nxt == S_CS_HOLD);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      tmr      <= '0;
      byte_idx <= '0;
      frame    <= 2'd0;
      err      <= 1'b0;
      ssn      <= 1'b1;
      req      <= 1'b0;
      wdata    <= 8'h00;
      for (int k = 0; k < CFG_REG_NUM; k++) img_q[k] <= 8'h00;
    end else begin
      state    <= state_nxt;
      tmr      <= tmr_nxt;
      byte_idx <= byte_nxt;
      frame    <= frame_nxt;
      err      <= err_nxt;
      ssn      <= ssn_nxt;
      req      <= req_nxt;
      wdata    <= wdata_nxt;
      if (latch)
        for (int k = 0; k < CFG_REG_NUM; k++) img_q[k] <= i_cfg_data[8*k +: 8];
    end
  end

  assign o_cfg_busy   = (state != S_IDLE);
  assign o_cfg_done   = (state == S_FINISH) || (state == S_ABORT);
  assign o_cfg_err    = err;
  assign o_spi_ssn    = ssn;
  assign o_spicom_req = req;
  assign o_spi_wdata  = wdata;

endmodule

// File: tb/tb_gpx2_cfg_ctrl.sv
// Directed bench for gpx2_cfg_ctrl with a byte-level SPI slave responder.
// Honours GPX2_CFG_VERIFY_EN to select the expected frame list.
module tb_gpx2_cfg_ctrl;
  localparam int N = 17;
`ifdef GPX2_CFG_VERIFY_EN
  localparam int NB = 2*N + 4;
  localparam int NWIN = 4;
  localparam logic EXP_CORRUPT_ERR = 1'b1;
`else
  localparam int NB = N + 3;
  localparam int NWIN = 3;
  localparam logic EXP_CORRUPT_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           i_rst_n, i_cfg_start;
  logic [N*8-1:0] i_cfg_data;
  logic           o_cfg_busy, o_cfg_done, o_cfg_err, o_spi_ssn, o_spicom_req;
  logic [7:0]     o_spi_wdata;
  logic           i_spicom_ready, i_spi_rdvalid;
  logic [7:0]     i_spi_rdbyte;

  gpx2_cfg_ctrl dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_cfg_start(i_cfg_start), .i_cfg_data(i_cfg_data),
    .o_cfg_busy(o_cfg_busy), .o_cfg_done(o_cfg_done), .o_cfg_err(o_cfg_err),
    .o_spi_ssn(o_spi_ssn), .o_spicom_req(o_spicom_req), .o_spi_wdata(o_spi_wdata),
    .i_spicom_ready(i_spicom_ready), .i_spi_rdvalid(i_spi_rdvalid), .i_spi_rdbyte(i_spi_rdbyte)
  );

  // Slave: 0 = echo image, 1 = return FF for register 5 on readback, 2 = never respond.
  int         slave_mode;
  logic [7:0] smem [N];
  logic [7:0] s_op, s_resp;
  int         s_idx, s_delay;
  bit         s_pend;

  always @(negedge clk) begin
    i_spi_rdvalid = 1'b0;
    if (!i_rst_n || o_spi_ssn) begin
      s_pend = 1'b0; s_idx = 0; i_spicom_ready = 1'b1; i_spi_rdbyte = 8'h00;
    end else if (s_pend) begin
      if (s_delay == 0) begin
        i_spi_rdvalid = 1'b1; i_spi_rdbyte = s_resp; s_pend = 1'b0; i_spicom_ready = 1'b1;
      end else s_delay--;
    end else if (o_spicom_req) begin
      if (s_idx == 0) s_op = o_spi_wdata;
      else if (s_op == 8'h80 && s_idx <= N) smem[s_idx-1] = o_spi_wdata;
      s_resp = 8'h00;
      if (s_op == 8'h40 && s_idx >= 1 && s_idx <= N)
        s_resp = (slave_mode == 1 && s_idx == 6) ? 8'hFF : smem[s_idx-1];
      s_idx++;
      s_pend = 1'b1;
      s_delay = (slave_mode == 2) ? 1000000 : 2;
      i_spicom_ready = 1'b0;
    end
  end

  int errors = 0, checks = 0;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [N*8-1:0] im, input int i);
    if (i == 0) return 8'h30;
    if (i == 1) return 8'h80;
    if (i <= N + 1) return im[8*(i-2) +: 8];
`ifdef GPX2_CFG_VERIFY_EN
    if (i == N + 2) return 8'h40;
    if (i <= 2*N + 2) return 8'h00;
`endif
    return 8'h18;
  endfunction

  logic [7:0] mosi [64];
  int   nb, wins, min_gap, gap, min_setup, setup, first_req, done_cnt, done_cyc, busy_low, timed_out;
  logic err_done, ssn_done, ssn_rst, busy_rst, err_first, prev_ssn, saw_req_win;

  task automatic start_pulse(input logic [N*8-1:0] im);
    @(negedge clk);
    i_cfg_data = im;
    i_cfg_start = 1'b1;
  endtask

  task automatic run_seq(input int max_cyc, input int restart_at, input logic [N*8-1:0] alt, input int rst_byte);
    nb = 0; wins = 0; min_gap = 1000; gap = 0; min_setup = 1000; setup = 0; first_req = -1;
    done_cnt = 0; done_cyc = -1; busy_low = 0; timed_out = 1; prev_ssn = 1'b1; saw_req_win = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      i_cfg_start = (c == restart_at);
      if (c == restart_at) i_cfg_data = alt;
      if (c == 0) err_first = o_cfg_err;
      if (!o_cfg_busy) busy_low++;
      if (prev_ssn && !o_spi_ssn) begin
        wins++;
        if (wins > 1 && gap < min_gap) min_gap = gap;
        setup = 0; saw_req_win = 1'b0;
      end
      if (o_spi_ssn) gap++; else gap = 0;
      if (!o_spi_ssn && !saw_req_win && !o_spicom_req) setup++;
      if (o_spicom_req) begin
        if (!saw_req_win && setup < min_setup) min_setup = setup;
        saw_req_win = 1'b1;
        if (nb < 64) mosi[nb] = o_spi_wdata;
        nb++;
        if (first_req < 0) first_req = c;
      end
      prev_ssn = o_spi_ssn;
      if (o_cfg_done) begin
        done_cnt++; done_cyc = c; err_done = o_cfg_err; ssn_done = o_spi_ssn; timed_out = 0;
        break;
      end
      if (rst_byte > 0 && nb == rst_byte) begin
        #2 i_rst_n = 1'b0;
        #1 ssn_rst = o_spi_ssn; busy_rst = o_cfg_busy; timed_out = 0;
        break;
      end
    end
  endtask

  task automatic watch_done(input int n, output int cnt);
    cnt = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (o_cfg_done) cnt++;
    end
  endtask

  function automatic int stream_mismatches(input logic [N*8-1:0] im);
    int m = 0;
    for (int i = 0; i < NB; i++) if (mosi[i] !== exp_byte(im, i)) m++;
    return m;
  endfunction

  logic [N*8-1:0] img_a, img_b;
  int extra;

  initial begin
    for (int k = 0; k < N; k++) begin
      img_a[8*k +: 8] = 8'(k + 1);
      img_b[8*k +: 8] = 8'(8'hA0 + k);
    end
    slave_mode = 0;
    i_rst_n = 1'b0; i_cfg_start = 1'b0; i_cfg_data = '0;
    repeat (3) @(negedge clk);
    i_rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", o_cfg_busy, 1'b0);
    check("rst_done", o_cfg_done, 1'b0);
    check("rst_err", o_cfg_err, 1'b0);
    check("rst_ssn", o_spi_ssn, 1'b1);
    check("rst_req", o_spicom_req, 1'b0);
    check("rst_wdata", o_spi_wdata, 8'h00);

    // Nominal run with echoing slave.
    start_pulse(img_a);
    run_seq(3000, -1, img_a, -1);
    check("run1_timeout", timed_out, 0);
    check("run1_nbytes", nb, NB);
    for (int i = 0; i < NB; i++) check($sformatf("run1_byte%0d", i), mosi[i], exp_byte(img_a, i));
    check("run1_windows", wins, NWIN);
    check("run1_gap_ge8", min_gap >= 8, 1'b1);
    check("run1_setup_ge8", min_setup >= 8, 1'b1);
    check("run1_err", err_done, 1'b0);
    check("run1_busy_low", busy_low, 0);
    check("run1_ssn_done", ssn_done, 1'b1);
    watch_done(20, extra);
    check("run1_extra_done", extra, 0);

    // Readback corruption on register 5.
    slave_mode = 1;
    start_pulse(img_a);
    run_seq(3000, -1, img_a, -1);
    check("run2_timeout", timed_out, 0);
    check("run2_nbytes", nb, NB);
    check("run2_last_op", mosi[NB-1], 8'h18);
    check("run2_err", err_done, EXP_CORRUPT_ERR);

    // Silent slave: byte timeout.
    slave_mode = 2;
    start_pulse(img_a);
    run_seq(3000, -1, img_a, -1);
    check("tmo_timeout", timed_out, 0);
    check("tmo_nbytes", nb, 1);
    check("tmo_latency", done_cyc - first_req, 1023);
    check("tmo_ssn", ssn_done, 1'b1);
    check("tmo_err", err_done, 1'b1);
    check("tmo_busy_low", busy_low, 0);
    watch_done(20, extra);
    check("tmo_extra_done", extra, 0);

    // Second start mid-run with a different image must be ignored.
    slave_mode = 0;
    start_pulse(img_a);
    run_seq(3000, 50, img_b, -1);
    check("restart_err_clr", err_first, 1'b0);
    check("restart_timeout", timed_out, 0);
    check("restart_nbytes", nb, NB);
    check("restart_stream", stream_mismatches(img_a), 0);
    check("restart_err", err_done, 1'b0);
    check("restart_busy_low", busy_low, 0);

    // Reset in the middle of F1.
    i_cfg_data = img_a;
    start_pulse(img_a);
    run_seq(3000, -1, img_a, 5);
    check("midrst_reached", timed_out, 0);
    check("midrst_ssn", ssn_rst, 1'b1);
    check("midrst_busy", busy_rst, 1'b0);
    check("midrst_done", done_cnt, 0);
    watch_done(3, extra);
    @(negedge clk);
    i_rst_n = 1'b1;
    begin
      int post;
      watch_done(10, post);
      check("midrst_no_done", extra + post, 0);
    end
    start_pulse(img_a);
    run_seq(3000, -1, img_a, -1);
    check("post_timeout", timed_out, 0);
    check("post_nbytes", nb, NB);
    check("post_stream", stream_mismatches(img_a), 0);
    check("post_windows", wins, NWIN);
    check("post_err", err_done, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
